alu_sweep_checker: RTL

Hardware sweep engine for the 3-bit sign-magnitude `add_sub` unit. It drives every operand pair onto the adder/subtractor and samples the result and flags. It compares R/SF/ZF against an internal golden model and streams one record per vector over a valid/ready port. It sits beside `add_sub` in the ALU top as the consuming end of its interface, providing on-chip self-test in place of file-based logging.

---
 rtl/alu_sweep_checker.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/alu_sweep_checker.sv
// Exhaustive sweep engine for the 3-bit sign-magnitude add_sub unit: drives every
// operand pair, checks R/SF/ZF against a golden model and streams one record per vector.
module alu_sweep_checker #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  mode,
    output logic        alu_op,
    output logic [2:0]  alu_a,
    output logic [2:0]  alu_b,
    input  logic [3:0]  alu_r,
    input  logic        alu_sf,
    input  logic        alu_zf,
    input  logic        alu_dzf,
    output logic        rec_valid,
    input  logic        rec_ready,
    output logic [14:0] rec_data,
    output logic        busy,
    output logic        done,
    output logic [7:0]  err_count
);

    localparam int unsigned VEC_W = 7;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned REC_W = 15;
    localparam int unsigned ERR_W = 8;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [VEC_W-1:0] VEC_FIRST_SUB = VEC_W'(64);
    localparam logic [VEC_W-1:0] VEC_LAST_ADD  = VEC_W'(63);
    localparam logic [VEC_W-1:0] VEC_LAST      = VEC_W'(127);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_EMIT,
        ST_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [VEC_W-1:0]   vec, vec_nxt;
    logic [VEC_W-1:0]   vec_end, vec_end_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               alu_op_nxt;
    logic [2:0]         alu_a_nxt, alu_b_nxt;
    logic               rec_valid_nxt;
    logic [REC_W-1:0]   rec_data_nxt;
    logic               busy_nxt;
    logic               done_nxt;
    logic [ERR_W-1:0]   err_count_nxt;

    logic [VEC_W-1:0]   first_idx_c, last_idx_c;
    logic signed [3:0]  sa_c, sb_c, res_c;
    logic [3:0]         mag_c;
    logic [3:0]         gold_r_c;
    logic               gold_sf_c, gold_zf_c;
    logic               mismatch_c;

    // Sweep range selected by mode; 11 behaves like 00.
    always_comb begin
        first_idx_c = '0;
        last_idx_c  = VEC_LAST;
        case (mode)
            2'b01:   last_idx_c  = VEC_LAST_ADD;
            2'b10:   first_idx_c = VEC_FIRST_SUB;
            default: ;
        endcase
    end

    // Golden model of the current vector; -0 operands collapse to 0 and a zero result is +0.
    always_comb begin
        sa_c = $signed({2'b00, vec[4:3]});
        sb_c = $signed({2'b00, vec[1:0]});
        if (vec[5]) sa_c = -sa_c;
        if (vec[2]) sb_c = -sb_c;
        res_c     = vec[6] ? (sa_c - sb_c) : (sa_c + sb_c);
        mag_c     = res_c[3] ? 4'(-res_c) : 4'(res_c);
        gold_r_c  = {res_c[3], mag_c[2:0]};
        gold_sf_c = res_c[3];
        gold_zf_c = (res_c == 4'sd0);
        mismatch_c = (alu_r != gold_r_c) | (alu_sf != gold_sf_c) | (alu_zf != gold_zf_c);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt     = state;
        vec_nxt       = vec;
        vec_end_nxt   = vec_end;
        cnt_nxt       = cnt;
        alu_op_nxt    = alu_op;
        alu_a_nxt     = alu_a;
        alu_b_nxt     = alu_b;
        rec_data_nxt  = rec_data;
        done_nxt      = done;
        err_count_nxt = err_count;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt     = ST_DRIVE;
                    vec_nxt       = first_idx_c;
                    vec_end_nxt   = last_idx_c;
                    cnt_nxt       = '0;
                    err_count_nxt = '0;
                    done_nxt      = 1'b0;
                end
            end
            ST_DRIVE: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = ST_SAMPLE;
                end else begin
                    cnt_nxt = CNT_W'(cnt + 1'b1);
                end
            end
            ST_SAMPLE: begin
                state_nxt    = ST_EMIT;
                rec_data_nxt = {vec, alu_r, alu_sf, alu_zf, alu_dzf, mismatch_c};
                if (mismatch_c) err_count_nxt = ERR_W'(err_count + 1'b1);
            end
            ST_EMIT: begin
                if (rec_ready) begin
                    if (vec == vec_end) begin
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = ST_DRIVE;
                        vec_nxt   = VEC_W'(vec + 1'b1);
                        cnt_nxt   = '0;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Operands change only on entry to DRIVE so they stay put through SAMPLE and EMIT.
        if ((state_nxt == ST_DRIVE) && (state != ST_DRIVE)) begin
            {alu_op_nxt, alu_a_nxt, alu_b_nxt} = vec_nxt;
        end

        busy_nxt      = (state_nxt == ST_DRIVE) || (state_nxt == ST_SAMPLE) || (state_nxt == ST_EMIT);
        rec_valid_nxt = (state_nxt == ST_EMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            vec       <= '0;
            vec_end   <= '0;
            cnt       <= '0;
            alu_op    <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            rec_valid <= 1'b0;
            rec_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_nxt;
            vec       <= vec_nxt;
            vec_end   <= vec_end_nxt;
            cnt       <= cnt_nxt;
            alu_op    <= alu_op_nxt;
            alu_a     <= alu_a_nxt;
            alu_b     <= alu_b_nxt;
            rec_valid <= rec_valid_nxt;
            rec_data  <= rec_data_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            err_count <= err_count_nxt;
        end
    end

endmodule
